dds_tdm_gain_packer: RTL



---
 rtl/dds_pkg.sv | 35 +++
 rtl/dds_sync_fifo.sv | 66 ++++++
 rtl/dds_tdm_gain_packer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared widths, Q1.15 constants and the FIFO entry type for the DDS output path.
package dds_pkg;

    localparam int SAMPLE_W = 16;
    localparam int CH_W     = 5;
    localparam int GAIN_W   = 16;

    localparam int Q15_ROUND = 16384;
    localparam int SAT_MAX   = 32767;
    localparam int SAT_MIN   = -32768;

    typedef struct packed {
        logic                sof;
        logic [CH_W-1:0]     channel;
        logic [SAMPLE_W-1:0] sample;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    // Round half up a Q2.30 product back to Q1.15 and clamp to the sample range.
    function automatic logic [SAMPLE_W-1:0] q15_round_sat(
        input logic signed [SAMPLE_W+GAIN_W-1:0] prod
    );
        int acc;
        acc = int'(prod) + Q15_ROUND;
        acc = acc >>> 15;
        if (acc > SAT_MAX) begin
            acc = SAT_MAX;
        end else if (acc < SAT_MIN) begin
            acc = SAT_MIN;
        end
        return acc[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/dds_sync_fifo.sv
// Single-clock show-ahead FIFO. A push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle; otherwise it is dropped and drop_o pulses.
module dds_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             drop_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // Flags, handshake qualification and the zeroed head while empty.
    always_comb begin
        empty_o = (count_q == '0);
        full_o  = (count_q == CW'(DEPTH));
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & (~full_o | do_pop);
        drop_o  = push_i & ~do_push;
        head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dds_tdm_gain_packer.sv
// Per-channel Q1.15 gain on the DDS TDM stream, buffered onto a valid/ready output.
// Three pipeline stages (capture + gain read, multiply, round/saturate) feed the FIFO.
module dds_tdm_gain_packer
    import dds_pkg::*;
#(
    parameter int unsigned       NUM_CH     = 32,
    parameter int unsigned       FIFO_DEPTH = 16,
    parameter logic [GAIN_W-1:0] GAIN_RESET = 16'h7FFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] in_sample,
    input  logic [CH_W-1:0]     in_channel,
    input  logic                in_valid,
    input  logic                gain_wr_en,
    input  logic [CH_W-1:0]     gain_addr,
    input  logic [GAIN_W-1:0]   gain_data,
    output logic [SAMPLE_W-1:0] out_data,
    output logic [CH_W-1:0]     out_channel,
    output logic                out_sof,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          overflow_count,
    output logic                bad_channel
);

    // Full index space is allocated; entries at or above NUM_CH are never written.
    localparam int unsigned NUM_GAIN = 2 ** CH_W;

    logic [GAIN_W-1:0] gain_q [NUM_GAIN];

    logic                       s1_valid_q;
    logic [CH_W-1:0]            s1_ch_q;
    logic signed [SAMPLE_W-1:0] s1_sample_q;
    logic signed [GAIN_W-1:0]   s1_gain_q;

    logic                              s2_valid_q;
    logic [CH_W-1:0]                   s2_ch_q;
    logic signed [SAMPLE_W+GAIN_W-1:0] s2_prod_q;

    logic        s3_valid_q;
    fifo_entry_t s3_entry_q;

    logic        in_legal;
    logic        gain_legal;
    logic [7:0]  overflow_q;
    logic        bad_channel_q;

    fifo_entry_t head;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_drop;
    logic        unused_fifo_full;

    // Channel range checks for the sample stream and the gain write port.
    always_comb begin
        in_legal   = 32'(in_channel) < NUM_CH;
        gain_legal = 32'(gain_addr) < NUM_CH;
    end

    // Gain register file; S1 samples the pre-write value on a same-cycle collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_GAIN; i++) begin
                gain_q[i] <= GAIN_RESET;
            end
        end else if (gain_wr_en && gain_legal) begin
            gain_q[gain_addr] <= gain_data;
        end
    end

    // Three-stage datapath: capture + gain read, multiply, round/saturate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_ch_q     <= '0;
            s1_sample_q <= '0;
            s1_gain_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_ch_q     <= '0;
            s2_prod_q   <= '0;
            s3_valid_q  <= 1'b0;
            s3_entry_q  <= '0;
        end else begin
            s1_valid_q  <= in_valid & in_legal;
            s1_ch_q     <= in_channel;
            s1_sample_q <= in_sample;
            s1_gain_q   <= gain_q[in_channel];

            s2_valid_q  <= s1_valid_q;
            s2_ch_q     <= s1_ch_q;
            s2_prod_q   <= 32'(s1_sample_q) * 32'(s1_gain_q);

            s3_valid_q         <= s2_valid_q;
            s3_entry_q.sof     <= (s2_ch_q == '0);
            s3_entry_q.channel <= s2_ch_q;
            s3_entry_q.sample  <= q15_round_sat(s2_prod_q);
        end
    end

    // Sticky illegal-channel flag and saturating drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bad_channel_q <= 1'b0;
            overflow_q    <= '0;
        end else begin
            if (in_valid && !in_legal) begin
                bad_channel_q <= 1'b1;
            end
            if (fifo_drop && overflow_q != 8'hFF) begin
                overflow_q <= overflow_q + 8'd1;
            end
        end
    end

    dds_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (s3_valid_q),
        .push_data_i (s3_entry_q),
        .pop_i       (out_ready),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .drop_o      (fifo_drop)
    );

    assign unused_fifo_full = fifo_full;

    // Output stream is the FIFO head; the FIFO zeroes it while empty.
    always_comb begin
        out_valid      = ~fifo_empty;
        out_data       = head.sample;
        out_channel    = head.channel;
        out_sof        = head.sof;
        overflow_count = overflow_q;
        bad_channel    = bad_channel_q;
    end

endmodule
